reg_move_ctrl: RTL

- Parametrised register-transfer sequencer for the simple CPU's MOVE instruction (opcode 0111).
- Drives one-hot read/write enables onto the register-file bus.
- Generalises the single-transfer move to N architectural registers and to burst moves of up to 2^CNT_W-1 consecutive register pairs, with index wrap-around, illegal-index error reporting and registered glitch-free outputs.
- Sits between the instruction decoder/control FSM and the register file.

---
 rtl/reg_move_pkg.sv | 16 +
 rtl/idx_onehot_dec.sv | 20 ++
 rtl/reg_move_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_move_pkg.sv
// Shared types and default sizing for the MOVE-instruction register transfer sequencer.
package reg_move_pkg;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DONE
   } state_t;

   // P0 sits directly above the four general registers R0..R3
   localparam int P0_IDX       = 4;
   localparam int DEF_NUM_REGS = P0_IDX + 1;
   localparam int DEF_IDX_W    = 6;
   localparam int DEF_CNT_W    = 3;

endpackage

// File: rtl/idx_onehot_dec.sv
// Binary register index to one-hot enable vector, with a flag saying the index names a real register.
module idx_onehot_dec #(
   parameter int NUM_REGS = 5,
   parameter int IDX_W    = 6
) (
   input  logic [IDX_W-1:0]    idx,
   output logic [NUM_REGS-1:0] onehot,
   output logic                valid
);

   // Decode one bit per register; indices at or above NUM_REGS leave the vector empty and clear valid
   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         onehot[i] = (idx == IDX_W'(i));
      end
      valid = ({1'b0, idx} < (IDX_W+1)'(NUM_REGS));
   end

endmodule

// File: rtl/reg_move_ctrl.sv
// Sequencer for MOVE: walks one or more consecutive dst/src register pairs and drives
// registered one-hot write/read enables onto the register-file bus.
module reg_move_ctrl
   import reg_move_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int IDX_W    = DEF_IDX_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [IDX_W-1:0]    dst_idx,
   input  logic [IDX_W-1:0]    src_idx,
   input  logic [CNT_W-1:0]    count,
   output logic [NUM_REGS-1:0] write_en,
   output logic [NUM_REGS-1:0] read_en,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    dst_q, dst_d, src_q, src_d;
   logic [CNT_W-1:0]    rem_q, rem_d;
   logic                err_q, err_d;
   logic [IDX_W:0]      dst_inc, src_inc;
   logic [NUM_REGS-1:0] dst_oh, src_oh;
   logic                dst_ok, src_ok;

   // One extra bit keeps the increment from overflowing when NUM_REGS fills the index space
   assign dst_inc = {1'b0, dst_q} + (IDX_W+1)'(1);
   assign src_inc = {1'b0, src_q} + (IDX_W+1)'(1);

   idx_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dst_dec (
      .idx    (dst_d),
      .onehot (dst_oh),
      .valid  (dst_ok)
   );

   idx_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_src_dec (
      .idx    (src_d),
      .onehot (src_oh),
      .valid  (src_ok)
   );

   // Index and remaining-count update: capture on accept, step and wrap independently during a burst
   always_comb begin
      dst_d = dst_q;
      src_d = src_q;
      rem_d = rem_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dst_d = dst_idx;
               src_d = src_idx;
               rem_d = (count == '0) ? CNT_W'(1) : count;
            end
         end
         XFER: begin
            if (rem_q > CNT_W'(1)) begin
               dst_d = (dst_inc >= NUM_REGS_W) ? '0 : dst_inc[IDX_W-1:0];
               src_d = (src_inc >= NUM_REGS_W) ? '0 : src_inc[IDX_W-1:0];
               rem_d = rem_q - CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Next state; an illegal start index skips the transfer phase and goes straight to DONE with err
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (dst_ok && src_ok) begin
                  state_d = XFER;
                  err_d   = 1'b0;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         XFER: begin
            if (rem_q <= CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and burst bookkeeping registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dst_q   <= '0;
         src_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   // Outputs are flops loaded from the upcoming state, so the bus sees glitch-free, contiguous enables
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_en <= '0;
         read_en  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         write_en <= (state_d == XFER) ? dst_oh : '0;
         read_en  <= (state_d == XFER) ? src_oh : '0;
         busy     <= (state_d != IDLE);
         done     <= (state_d == DONE);
         err      <= (state_d == DONE) && err_d;
      end
   end

endmodule
